// File: rtl/uart_rx_os16_pkg.sv
// Shared types and constants for the 16x oversampling UART receiver.
package uart_rx_os16_pkg;

    // Receiver frame states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int OS_RATE   = 16;
    localparam int SAMP_W    = $clog2(OS_RATE);
    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    localparam logic [SAMP_W-1:0] SAMP_LO   = SAMP_W'(7);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(8);
    localparam logic [SAMP_W-1:0] SAMP_HI   = SAMP_W'(9);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(15);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    // Two-out-of-three vote over the mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk_50m,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..DIV-1 and wrap; the tick marks the last count of each period.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling 8N1 UART receiver with majority voting, false-start
// rejection, framing/overrun flags and break recovery.
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       rx,
    input  logic       ready_clr,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD * OS_RATE);

    generate
        if (TICK_DIV < 2) begin : g_bad_div
            $error("uart_rx_os16: CLK_FREQ/(BAUD*16) must be at least 2");
        end
    endgenerate

    logic                 tick;
    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state;
    logic [SAMP_W-1:0]    samp;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic                 s_lo;
    logic                 s_mid;
    logic [7:0]           shift;
    logic                 maj;

    uart_baud_tick #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk_50m(clk_50m),
        .rst    (rst),
        .tick   (tick)
    );

    // Bring the asynchronous line into the clock domain; idle-high after reset.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // The third vote is the live sample taken at SAMP_HI itself.
    assign maj = majority3(s_lo, s_mid, rx_s);

    // Frame FSM, shift register and hand-off flags; ready_clr acts every clock,
    // everything else only on ticks, and a completion overrides ready_clr.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state     <= IDLE;
            samp      <= '0;
            bit_idx   <= '0;
            s_lo      <= 1'b1;
            s_mid     <= 1'b1;
            shift     <= '0;
            data_out  <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ready_clr) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end

            if (tick) begin
                if (state == START || state == DATA || state == STOP) begin
                    samp <= samp + SAMP_W'(1);
                    if (samp == SAMP_LO) begin
                        s_lo <= rx_s;
                    end
                    if (samp == SAMP_MID) begin
                        s_mid <= rx_s;
                    end
                end

                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            samp  <= SAMP_W'(1);
                        end
                    end

                    START: begin
                        if (samp == SAMP_HI && maj) begin
                            state <= IDLE;
                            samp  <= '0;
                        end else if (samp == SAMP_LAST) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end

                    DATA: begin
                        if (samp == SAMP_HI) begin
                            shift[bit_idx] <= maj;
                        end
                        if (samp == SAMP_LAST) begin
                            if (bit_idx == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + BIT_IDX_W'(1);
                            end
                        end
                    end

                    STOP: begin
                        if (samp == SAMP_HI) begin
                            data_out  <= shift;
                            ready     <= 1'b1;
                            frame_err <= ~maj;
                            if (ready && !ready_clr) begin
                                overrun <= 1'b1;
                            end
                            samp  <= '0;
                            state <= maj ? IDLE : WAIT_HIGH;
                        end
                    end

                    WAIT_HIGH: begin
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        samp  <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed self-checking bench for uart_rx_os16 at 432 clocks per bit.
module tb_uart_rx_os16;

    localparam int BIT_CLKS = 432;

    logic       clk_50m = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready_clr = 1'b0;
    logic [7:0] data_out;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    uart_rx_os16 #(
        .CLK_FREQ(50000000),
        .BAUD    (115200)
    ) dut (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .rx       (rx),
        .ready_clr(ready_clr),
        .data_out (data_out),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    // 50 MHz clock.
    always #10 clk_50m = ~clk_50m;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    // Drive one 8N1 frame; the line is left at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_val;
        wait_clks(BIT_CLKS);
    endtask

    task automatic pulse_clr();
        ready_clr = 1'b1;
        wait_clks(1);
        ready_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(3);
        checks++;
        if ({data_out, ready, frame_err, overrun, busy} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got data=%h rdy=%b fe=%b ov=%b busy=%b expected all 0",
                     data_out, ready, frame_err, overrun, busy);
        end
        rst = 1'b0;
        wait_clks(100);
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got rdy=%b busy=%b expected 0 0", ready, busy);
        end
    endtask

    task automatic test_single();
        send_byte(8'hAB, 1'b1);
        checks++;
        if (ready !== 1'b1 || data_out !== 8'hAB) begin
            errors++;
            $display("[TB] FAIL single_byte: got rdy=%b data=%h expected 1 ab", ready, data_out);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_flags: got fe=%b ov=%b expected 0 0", frame_err, overrun);
        end
        pulse_clr();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_clr: got rdy=%b expected 0", ready);
        end
        wait_clks(1000);
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: got rdy=%b busy=%b expected 0 0", ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                send_byte(8'h3F, 1'b1);
                send_byte(8'h55, 1'b1);
            end
            begin
                logic [7:0] exp_b [2];
                exp_b[0] = 8'h3F;
                exp_b[1] = 8'h55;
                for (int k = 0; k < 2; k++) begin
                    for (int t = 0; t < 6000 && ready !== 1'b1; t++) begin
                        wait_clks(1);
                    end
                    checks++;
                    if (ready !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL b2b_timeout: got rdy=%b expected 1 for byte %0d", ready, k);
                    end
                    checks++;
                    if (data_out !== exp_b[k] || frame_err !== 1'b0 || overrun !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL b2b_byte%0d: got data=%h fe=%b ov=%b expected %h 0 0",
                                 k, data_out, frame_err, overrun, exp_b[k]);
                    end
                    pulse_clr();
                end
            end
        join
        wait_clks(500);
    endtask

    task automatic test_false_start();
        logic seen_busy;
        seen_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (i == 100) rx = 1'b1;
            wait_clks(1);
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        checks++;
        if (seen_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_busy_pulse: got seen=%b expected 1", seen_busy);
        end
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_reject: got busy=%b rdy=%b expected 0 0", busy, ready);
        end
    endtask

    task automatic test_break();
        send_byte(8'hC3, 1'b0);
        checks++;
        if (data_out !== 8'hC3 || ready !== 1'b1 || frame_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL break_byte: got data=%h rdy=%b fe=%b expected c3 1 1",
                     data_out, ready, frame_err);
        end
        wait_clks(2000);
        checks++;
        if (busy !== 1'b1 || data_out !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL break_hold: got busy=%b data=%h expected 1 c3", busy, data_out);
        end
        rx = 1'b1;
        wait_clks(80);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL break_release: got busy=%b expected 0", busy);
        end
        pulse_clr();
        checks++;
        if (ready !== 1'b0 || frame_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL break_clr: got rdy=%b fe=%b expected 0 1", ready, frame_err);
        end
        send_byte(8'h12, 1'b1);
        checks++;
        if (data_out !== 8'h12 || ready !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL break_next: got data=%h rdy=%b fe=%b expected 12 1 0",
                     data_out, ready, frame_err);
        end
        pulse_clr();
        wait_clks(500);
    endtask

    task automatic test_overrun();
        send_byte(8'h01, 1'b1);
        checks++;
        if (data_out !== 8'h01 || ready !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_first: got data=%h rdy=%b ov=%b expected 01 1 0",
                     data_out, ready, overrun);
        end
        wait_clks(BIT_CLKS);
        send_byte(8'h02, 1'b1);
        checks++;
        if (data_out !== 8'h02 || ready !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovr_second: got data=%h rdy=%b ov=%b expected 02 1 1",
                     data_out, ready, overrun);
        end
        pulse_clr();
        checks++;
        if (ready !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_clr: got rdy=%b ov=%b expected 0 0", ready, overrun);
        end
        wait_clks(500);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h77;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        rx = b[3];
        wait_clks(200);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_busy_before: got busy=%b expected 1", busy);
        end
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        checks++;
        if ({data_out, ready, frame_err, overrun, busy} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got data=%h rdy=%b fe=%b ov=%b busy=%b expected all 0",
                     data_out, ready, frame_err, overrun, busy);
        end
        rx = 1'b1;
        wait_clks(2000);
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_no_ready: got rdy=%b busy=%b expected 0 0", ready, busy);
        end
        send_byte(8'h5A, 1'b1);
        checks++;
        if (data_out !== 8'h5A || ready !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_next: got data=%h rdy=%b fe=%b ov=%b expected 5a 1 0 0",
                     data_out, ready, frame_err, overrun);
        end
        pulse_clr();
        wait_clks(200);
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting uart_rx_os16 bench");
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
